// File: rtl/regfile.sv
// regfile: 32 x DATA_W general-purpose register file for the single-cycle datapath.
// Two combinational read ports (A, B), one synchronous write port (W).
// r0 is hardwired to zero; r1..r31 clear asynchronously on rst_n low.
// Ports:
//   clk    - system clock, writes on rising edge
//   WE     - write enable (active high)
//   rW     - write address
//   rA/rB  - read addresses for ports A/B
//   W      - write data
//   A/B    - read data (combinational)
//   rst_n  - async active-low reset
module regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              WE,
  input  logic [ADDR_W-1:0] rW,
  input  logic [ADDR_W-1:0] rA,
  input  logic [ADDR_W-1:0] rB,
  input  logic [DATA_W-1:0] W,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic              rst_n
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  // Read view of every register; entry 0 is a constant zero.
  logic [DATA_W-1:0] rd [NREGS];

  assign rd[0] = '0;

  // One storage register per address. The per-register decode compares rW
  // against a constant, so an unknown rW never matches a known index and
  // cannot spill a write into an unrelated register.
  for (genvar i = 1; i < NREGS; i++) begin : gen_reg
    logic [DATA_W-1:0] q;
    logic              we_i;

    assign we_i = WE && (rW == ADDR_W'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (we_i) begin
        q <= W;
      end
    end

    assign rd[i] = q;
  end

  // Combinational read ports; no write-to-read bypass.
  assign A = rd[rA];
  assign B = rd[rB];

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile.
module tb_regfile;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              WE;
  logic [ADDR_W-1:0] rW;
  logic [ADDR_W-1:0] rA;
  logic [ADDR_W-1:0] rB;
  logic [DATA_W-1:0] W;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;

  int passed;
  int total;

  regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .WE   (WE),
    .rW   (rW),
    .rA   (rA),
    .rB   (rB),
    .W    (W),
    .A    (A),
    .B    (B),
    .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    WE = 1'b1; rW = 5'd1; W = 32'hDEADBEEF; rA = 5'd1; rB = 5'd31;
    #1;
    total++;
    if (A !== 32'h0) $display("FAIL reset_a: got %h want %h", A, 32'h0); else passed++;
    total++;
    if (B !== 32'h0) $display("FAIL reset_b: got %h want %h", B, 32'h0); else passed++;
    // A clock edge during reset must not write.
    @(posedge clk); #1;
    total++;
    if (A !== 32'h0) $display("FAIL reset_hold: got %h want %h", A, 32'h0); else passed++;
    @(negedge clk);
    WE = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_write_disable();
    @(negedge clk);
    WE = 1'b0; rW = 5'd1; W = 32'hFFFFFFFF; rA = 5'd1; rB = 5'd2;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (A !== 32'h0) $display("FAIL wdis_a: got %h want %h", A, 32'h0); else passed++;
    total++;
    if (B !== 32'h0) $display("FAIL wdis_b: got %h want %h", B, 32'h0); else passed++;
  endtask

  task automatic test_write_r1();
    @(negedge clk);
    WE = 1'b1; rW = 5'd1; W = 32'hFFFFFFFF; rA = 5'd1; rB = 5'd2;
    #1;
    total++;
    if (A !== 32'h0) $display("FAIL r1_nobypass: got %h want %h", A, 32'h0); else passed++;
    @(posedge clk); #1;
    total++;
    if (A !== 32'hFFFFFFFF) $display("FAIL r1_a: got %h want %h", A, 32'hFFFFFFFF); else passed++;
    total++;
    if (B !== 32'h0) $display("FAIL r1_b: got %h want %h", B, 32'h0); else passed++;
  endtask

  task automatic test_write_r2();
    @(negedge clk);
    WE = 1'b1; rW = 5'd2; W = 32'h88888888; rA = 5'd1; rB = 5'd2;
    @(posedge clk); #1;
    total++;
    if (B !== 32'h88888888) $display("FAIL r2_b: got %h want %h", B, 32'h88888888); else passed++;
    total++;
    if (A !== 32'hFFFFFFFF) $display("FAIL r2_a: got %h want %h", A, 32'hFFFFFFFF); else passed++;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    rA = 5'd0; rB = 5'd1;
    #1;
    total++;
    if (A !== 32'h0) $display("FAIL zero_read: got %h want %h", A, 32'h0); else passed++;
    WE = 1'b1; rW = 5'd0; W = 32'h12345678;
    @(posedge clk); #1;
    total++;
    if (A !== 32'h0) $display("FAIL zero_write: got %h want %h", A, 32'h0); else passed++;
    total++;
    if (B !== 32'hFFFFFFFF) $display("FAIL zero_r1_kept: got %h want %h", B, 32'hFFFFFFFF); else passed++;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic test_dual_port();
    @(negedge clk);
    rA = 5'd2; rB = 5'd2;
    #1;
    total++;
    if (A !== 32'h88888888) $display("FAIL dual_a: got %h want %h", A, 32'h88888888); else passed++;
    total++;
    if (B !== 32'h88888888) $display("FAIL dual_b: got %h want %h", B, 32'h88888888); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] vals [4];
    vals[0] = 32'hA5A5_0003;
    vals[1] = 32'h5A5A_0004;
    vals[2] = 32'h0F0F_0005;
    vals[3] = 32'hF0F0_0006;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      WE = 1'b1; rW = ADDR_W'(3 + i); W = vals[i];
      rA = ADDR_W'(3 + i); rB = (i == 0) ? 5'd2 : ADDR_W'(2 + i);
      #1;
      // Target still holds its old (reset) value before the edge.
      total++;
      if (A !== 32'h0) $display("FAIL b2b_pre_r%0d: got %h want %h", 3 + i, A, 32'h0); else passed++;
      @(posedge clk); #1;
      total++;
      if (A !== vals[i]) $display("FAIL b2b_post_r%0d: got %h want %h", 3 + i, A, vals[i]); else passed++;
    end
    @(negedge clk);
    WE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rB = ADDR_W'(3 + i);
      #1;
      total++;
      if (B !== vals[i]) $display("FAIL b2b_read_r%0d: got %h want %h", 3 + i, B, vals[i]); else passed++;
    end
  endtask

  task automatic test_top_reg();
    @(negedge clk);
    WE = 1'b1; rW = 5'd31; W = 32'hC0DE_F00D; rA = 5'd31; rB = 5'd30;
    @(posedge clk); #1;
    total++;
    if (A !== 32'hC0DE_F00D) $display("FAIL r31_a: got %h want %h", A, 32'hC0DEF00D); else passed++;
    total++;
    if (B !== 32'h0) $display("FAIL r30_b: got %h want %h", B, 32'h0); else passed++;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic test_async_reset();
    // Pending write to r7 set up, then reset pulled low before its edge.
    @(negedge clk);
    WE = 1'b1; rW = 5'd7; W = 32'h7777_7777; rA = 5'd1; rB = 5'd2;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (A !== 32'h0) $display("FAIL arst_a: got %h want %h", A, 32'h0); else passed++;
    total++;
    if (B !== 32'h0) $display("FAIL arst_b: got %h want %h", B, 32'h0); else passed++;
    @(posedge clk);
    #2;
    WE = 1'b0;
    rst_n = 1'b1;
    #1;
    rA = 5'd1; rB = 5'd2;
    #1;
    total++;
    if (A !== 32'h0) $display("FAIL arst_r1: got %h want %h", A, 32'h0); else passed++;
    total++;
    if (B !== 32'h0) $display("FAIL arst_r2: got %h want %h", B, 32'h0); else passed++;
    rA = 5'd7; rB = 5'd31;
    #1;
    total++;
    if (A !== 32'h0) $display("FAIL arst_r7_lost: got %h want %h", A, 32'h0); else passed++;
    total++;
    if (B !== 32'h0) $display("FAIL arst_r31: got %h want %h", B, 32'h0); else passed++;
    // First edge after release accepts a write.
    @(negedge clk);
    WE = 1'b1; rW = 5'd1; W = 32'h0000_0101; rA = 5'd1;
    @(posedge clk); #1;
    total++;
    if (A !== 32'h0000_0101) $display("FAIL arst_first_wr: got %h want %h", A, 32'h00000101); else passed++;
    @(negedge clk);
    WE = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n = 1'b0; WE = 1'b0; rW = '0; rA = '0; rB = '0; W = '0;
    test_reset();
    test_write_disable();
    test_write_r1();
    test_write_r2();
    test_zero_reg();
    test_dual_port();
    test_back_to_back();
    test_top_reg();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
